// File: rtl/code_lock_checker.sv
// code_lock_checker: assembles BCD digit entries, checks them against a
// secret code, and sequences open / failed-attempt lockout behaviour.
// Optional build macro CODE_LOCK_AUTO_RELOCK_EN adds an auto-relock timer
// to the OPEN state; without it OPEN persists until i_close or reset.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | no digits held, waiting for the first valid strobe
// S_ENTRY   | partial entry held, gap timer running
// S_CHECK   | one cycle: compare entry against p_code, clear buffer
// S_OPEN    | lock open, strobes ignored, waits for i_close (or relock)
// S_LOCKOUT | too many failures, all input ignored until timer expires

module code_lock_checker #(
  parameter int                    p_digits        = 4,
  parameter logic [4*p_digits-1:0] p_code          = 16'h1234,
  parameter int                    p_max_fail      = 3,
  parameter int                    p_lock_cycles   = 100_000_000,
  parameter int                    p_entry_timeout = 250_000_000,
  parameter int                    p_open_cycles   = 500_000_000
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic [3:0]                        i_code,
  input  logic                              i_code_vld,
  input  logic                              i_close,
  output logic                              o_open,
  output logic                              o_lockout,
  output logic                              o_err,
  output logic [3:0]                        o_entry [p_digits],
  output logic [$clog2(p_digits+1)-1:0]     o_entry_cnt,
  output logic [$clog2(p_max_fail+1)-1:0]   o_fail_cnt
);

  localparam int CW = $clog2(p_digits+1);
  localparam int FW = $clog2(p_max_fail+1);
  // One shared down-counter serves the gap, lockout and open timers since
  // they are never live at the same time; sized for the largest load.
  localparam int TMAX_A = (p_lock_cycles > p_entry_timeout) ? p_lock_cycles : p_entry_timeout;
  localparam int TMAX   = (p_open_cycles > TMAX_A) ? p_open_cycles : TMAX_A;
  localparam int TW     = $clog2(TMAX+1);

  typedef enum logic [2:0] {
    S_IDLE, S_ENTRY, S_CHECK, S_OPEN, S_LOCKOUT
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      entry_q [p_digits];
  logic [CW-1:0]   cnt_q, cnt_inc;
  logic [FW-1:0]   fail_q, fail_inc;
  logic [TW-1:0]   timer_q;
  logic            open_q, open_d;
  logic            lockout_q, lockout_d;
  logic            err_q, err_d;
  logic            digit_ok, last_digit, match, tmr_exp;

  assign digit_ok   = i_code_vld && (i_code <= 4'd9);
  assign cnt_inc    = cnt_q + CW'(1);
  assign last_digit = (cnt_inc == CW'(p_digits));
  assign fail_inc   = (fail_q == FW'(p_max_fail)) ? fail_q : fail_q + FW'(1);
  assign tmr_exp    = (timer_q == TW'(1));

  // Entry-vs-code compare; entry[0] is the newest digit = least significant nibble
  always_comb begin
    match = 1'b1;
    for (int i = 0; i < p_digits; i++) begin
      if (entry_q[i] != p_code[4*i +: 4]) match = 1'b0;
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (digit_ok) state_d = last_digit ? S_CHECK : S_ENTRY;
      end
      S_ENTRY: begin
        if (digit_ok)     state_d = last_digit ? S_CHECK : S_ENTRY;
        else if (tmr_exp) state_d = S_IDLE;
      end
      S_CHECK: begin
        if (match)                            state_d = S_OPEN;
        else if (fail_inc == FW'(p_max_fail)) state_d = S_LOCKOUT;
        else                                  state_d = S_IDLE;
      end
      S_OPEN: begin
        if (i_close) state_d = S_IDLE;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
        else if (tmr_exp) state_d = S_IDLE;
`endif
      end
      S_LOCKOUT: begin
        if (tmr_exp) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, registered below so the status flags come straight from flops
  always_comb begin
    open_d    = (state_d == S_OPEN);
    lockout_d = (state_d == S_LOCKOUT);
    err_d     = (state_q == S_CHECK) && !match;
  end

  // Entry buffer, counters, shared timer and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < p_digits; i++) entry_q[i] <= 4'd0;
      cnt_q     <= '0;
      fail_q    <= '0;
      timer_q   <= '0;
      open_q    <= 1'b0;
      lockout_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      open_q    <= open_d;
      lockout_q <= lockout_d;
      err_q     <= err_d;
      case (state_q)
        S_IDLE, S_ENTRY: begin
          if (digit_ok) begin
            for (int i = p_digits-1; i > 0; i--) entry_q[i] <= entry_q[i-1];
            entry_q[0] <= i_code;
            cnt_q      <= cnt_inc;
            timer_q    <= TW'(p_entry_timeout);
          end else if (state_q == S_ENTRY) begin
            if (tmr_exp) begin
              for (int i = 0; i < p_digits; i++) entry_q[i] <= 4'd0;
              cnt_q   <= '0;
              timer_q <= '0;
            end else if (timer_q != '0) begin
              timer_q <= timer_q - TW'(1);
            end
          end
        end
        S_CHECK: begin
          for (int i = 0; i < p_digits; i++) entry_q[i] <= 4'd0;
          cnt_q <= '0;
          if (match) begin
            fail_q <= '0;
`ifdef CODE_LOCK_AUTO_RELOCK_EN
            timer_q <= TW'(p_open_cycles);
`else
            timer_q <= '0;
`endif
          end else begin
            fail_q  <= fail_inc;
            timer_q <= (fail_inc == FW'(p_max_fail)) ? TW'(p_lock_cycles) : '0;
          end
        end
        S_OPEN: begin
`ifdef CODE_LOCK_AUTO_RELOCK_EN
          if (i_close || tmr_exp)    timer_q <= '0;
          else if (timer_q != '0)    timer_q <= timer_q - TW'(1);
`endif
        end
        S_LOCKOUT: begin
          if (tmr_exp) begin
            fail_q  <= '0;
            timer_q <= '0;
          end else if (timer_q != '0) begin
            timer_q <= timer_q - TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_open      = open_q;
  assign o_lockout   = lockout_q;
  assign o_err       = err_q;
  assign o_entry     = entry_q;
  assign o_entry_cnt = cnt_q;
  assign o_fail_cnt  = fail_q;

endmodule

// File: tb/tb_code_lock_checker.sv
// Self-checking bench for code_lock_checker with short timers.
module tb_code_lock_checker;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic [3:0] i_code = 4'd0;
  logic       i_code_vld = 1'b0;
  logic       i_close = 1'b0;
  logic       o_open, o_lockout, o_err;
  logic [3:0] o_entry [4];
  logic [2:0] o_entry_cnt;
  logic [1:0] o_fail_cnt;
  logic [15:0] entry_w;

  int total = 0;
  int bad   = 0;
  int exp_fail = 0;
  bit open_prev = 1'b0;

  typedef struct {
    bit open;
    bit lock;
    int fail;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;

  code_lock_checker #(
    .p_digits(4), .p_code(16'h1234), .p_max_fail(3),
    .p_lock_cycles(10), .p_entry_timeout(20), .p_open_cycles(15)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_code(i_code), .i_code_vld(i_code_vld),
    .i_close(i_close), .o_open(o_open), .o_lockout(o_lockout), .o_err(o_err),
    .o_entry(o_entry), .o_entry_cnt(o_entry_cnt), .o_fail_cnt(o_fail_cnt)
  );

  always #5 i_clk = ~i_clk;

  always_comb entry_w = {o_entry[3], o_entry[2], o_entry[1], o_entry[0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic strobe(input logic [3:0] d);
    i_code     = d;
    i_code_vld = 1'b1;
    @(negedge i_clk);
    i_code_vld = 1'b0;
  endtask

  // Enter a 4-digit code; push the expected outcome before the final digit.
  // Returns one cycle after CHECK, when o_open/o_err must be visible.
  task automatic enter(input logic [15:0] code, input bit hold_last);
    exp_t e;
    for (int k = 3; k >= 0; k--) begin
      if (k == 0) begin
        if (code == 16'h1234) begin
          exp_fail = 0;
          e.open = 1'b1; e.lock = 1'b0; e.fail = 0;
        end else begin
          exp_fail++;
          e.open = 1'b0; e.lock = (exp_fail == 3); e.fail = exp_fail;
        end
        sb_q.push_back(e);
      end
      strobe(code[4*k +: 4]);
      check("cnt_step", o_entry_cnt, 4 - k);
    end
    if (hold_last) strobe(4'd7);
    else           idle(1);
  endtask

  // Scoreboard consumer: every open rise or err pulse must match a queued outcome
  always @(negedge i_clk) begin
    if (o_err || (o_open && !open_prev)) begin
      check("sb_avail", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        sb_e = sb_q.pop_front();
        check("sb_open", o_open, sb_e.open);
        check("sb_err", o_err, !sb_e.open);
        check("sb_fail", o_fail_cnt, sb_e.fail);
        check("sb_lock", o_lockout, sb_e.lock);
      end
    end
    open_prev = o_open;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int k;
    idle(2);
    check("rst_open", o_open, 0);
    check("rst_lock", o_lockout, 0);
    check("rst_err", o_err, 0);
    check("rst_cnt", o_entry_cnt, 0);
    check("rst_fail", o_fail_cnt, 0);
    check("rst_entry", entry_w, 16'h0000);
    i_rst = 1'b1;
    idle(1);

    // correct code, then close
    enter(16'h1234, 1'b0);
    check("open_lat", o_open, 1);
    check("open_fail", o_fail_cnt, 0);
    i_close = 1'b1;
    idle(1);
    i_close = 1'b0;
    check("close", o_open, 0);

    // wrong code
    enter(16'h1235, 1'b0);
    check("err_pulse", o_err, 1);
    check("err_fail", o_fail_cnt, 1);
    check("err_entry", entry_w, 16'h0000);
    check("err_cnt", o_entry_cnt, 0);
    check("err_open", o_open, 0);
    idle(1);
    check("err_single", o_err, 0);

    // two more wrong -> lockout
    enter(16'h9999, 1'b0);
    check("fail2", o_fail_cnt, 2);
    enter(16'h4321, 1'b0);
    check("lock_on", o_lockout, 1);
    check("lock_fail", o_fail_cnt, 3);
    strobe(4'd1); strobe(4'd2); strobe(4'd3); strobe(4'd4);
    check("lock_cnt", o_entry_cnt, 0);
    check("lock_entry", entry_w, 16'h0000);
    check("lock_open", o_open, 0);
    idle(5);
    check("lock_last", o_lockout, 1);
    idle(1);
    check("lock_off", o_lockout, 0);
    check("lock_clr", o_fail_cnt, 0);
    exp_fail = 0;
    enter(16'h1234, 1'b0);
    check("post_lock_open", o_open, 1);
    i_close = 1'b1; idle(1); i_close = 1'b0;

    // entry timeout
    enter(16'h0000, 1'b0);
    idle(1);
    strobe(4'd1); strobe(4'd2);
    check("to_cnt2", o_entry_cnt, 2);
    check("to_entry2", entry_w, 16'h0012);
    idle(19);
    check("to_before", o_entry_cnt, 2);
    idle(1);
    check("to_cnt", o_entry_cnt, 0);
    check("to_entry", entry_w, 16'h0000);
    check("to_fail", o_fail_cnt, 1);
    strobe(4'd15);
    check("inv_idle", o_entry_cnt, 0);
    strobe(4'd1); strobe(4'd15);
    check("inv_cnt", o_entry_cnt, 1);
    check("inv_entry", entry_w, 16'h0001);
    idle(18);
    check("inv_no_tmr_a", o_entry_cnt, 1);
    idle(1);
    check("inv_no_tmr_b", o_entry_cnt, 0);

    // strobe ignored in OPEN; close beats simultaneous strobe
    enter(16'h1234, 1'b0);
    strobe(4'd5);
    check("open_ign_cnt", o_entry_cnt, 0);
    check("open_ign_open", o_open, 1);
    i_close = 1'b1; i_code = 4'd1; i_code_vld = 1'b1;
    idle(1);
    i_close = 1'b0; i_code_vld = 1'b0;
    check("cls_vld_open", o_open, 0);
    check("cls_vld_cnt", o_entry_cnt, 0);

    // strobe during CHECK dropped
    enter(16'h9876, 1'b1);
    check("chk_drop_cnt", o_entry_cnt, 0);
    check("chk_drop_entry", entry_w, 16'h0000);
    idle(1);

    // auto-relock behaviour
    enter(16'h1234, 1'b0);
`ifdef CODE_LOCK_AUTO_RELOCK_EN
    k = 0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge i_clk);
      if (!o_open) begin k = n; break; end
    end
    check("relock_cycles", k, 15);
`else
    idle(120);
    check("no_relock", o_open, 1);
    i_close = 1'b1; idle(1); i_close = 1'b0;
`endif
    check("relock_closed", o_open, 0);

    // async reset mid-entry
    enter(16'h5555, 1'b0);
    idle(1);
    strobe(4'd1); strobe(4'd2);
    #2 i_rst = 1'b0;
    #1;
    check("arst_cnt", o_entry_cnt, 0);
    check("arst_entry", entry_w, 16'h0000);
    check("arst_fail", o_fail_cnt, 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    exp_fail = 0;
    idle(1);

    // async reset mid-lockout
    enter(16'h1111, 1'b0);
    enter(16'h2222, 1'b0);
    enter(16'h3333, 1'b0);
    check("arst_lock_pre", o_lockout, 1);
    #2 i_rst = 1'b0;
    #1;
    check("arst_lock", o_lockout, 0);
    check("arst_lock_fail", o_fail_cnt, 0);
    @(negedge i_clk);
    i_rst = 1'b1;
    exp_fail = 0;
    idle(1);
    enter(16'h1234, 1'b0);
    check("final_open", o_open, 1);
    idle(2);

    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
